// File: rtl/level_sequencer_if.sv
// Game-state type and the mouse/player/status bundle between the game
// logic (master) and the level sequencer (slave).
package level_sequencer_pkg;
  typedef enum logic [2:0] {
    START, PLAY, LEVEL_UP, DEAD, GAME_OVER, FINISH
  } g_state;
endpackage

interface level_sequencer_if
  import level_sequencer_pkg::*;
#(
  parameter int N_LEVELS = 3,
  parameter int LIVES    = 3
) ();
  logic                              m_left;
  logic [11:0]                       xpos_mouse;
  logic [11:0]                       ypos_mouse;
  logic [11:0]                       ypos_player;
  logic                              player_hit;
  g_state                            game_state;
  logic [$clog2(N_LEVELS+1)-1:0]     level;
  logic [$clog2(LIVES+1)-1:0]        lives;
  logic                              level_start;

  modport master (
    output m_left, xpos_mouse, ypos_mouse, ypos_player, player_hit,
    input  game_state, level, lives, level_start
  );

  modport slave (
    input  m_left, xpos_mouse, ypos_mouse, ypos_player, player_hit,
    output game_state, level, lives, level_start
  );
endinterface

// File: rtl/level_sequencer.sv
// Level/lives sequencer for a click-to-start game: START -> PLAY with timed
// LEVEL_UP and DEAD hold states, ending in GAME_OVER or FINISH.
module level_sequencer
  import level_sequencer_pkg::*;
#(
  parameter int N_LEVELS = 3,
  parameter int LIVES    = 3,
  parameter int HOLD_CYC = 40_000_000,
  parameter int BTN_X0   = 160,
  parameter int BTN_X1   = 650,
  parameter int BTN_Y0   = 250,
  parameter int BTN_Y1   = 320,
  parameter int GOAL_Y   = 500
) (
  input  logic             clk_40,
  input  logic             rst,
  level_sequencer_if.slave bus
);
  localparam int LW  = $clog2(N_LEVELS + 1);
  localparam int LVW = $clog2(LIVES + 1);
  localparam int TW  = $clog2(HOLD_CYC + 1);

  localparam logic [LW-1:0]  LAST_LEVEL = LW'(N_LEVELS - 1);
  localparam logic [LVW-1:0] LIVES_INIT = LVW'(LIVES);
  localparam logic [TW-1:0]  HOLD_LAST  = TW'(HOLD_CYC - 1);
  localparam logic [11:0]    X0 = 12'(BTN_X0);
  localparam logic [11:0]    X1 = 12'(BTN_X1);
  localparam logic [11:0]    Y0 = 12'(BTN_Y0);
  localparam logic [11:0]    Y1 = 12'(BTN_Y1);
  localparam logic [11:0]    GY = 12'(GOAL_Y);

  g_state           state_q;
  logic [LW-1:0]    level_q;
  logic [LVW-1:0]   lives_q;
  logic             level_start_q;
  logic [TW-1:0]    timer_q;
  logic             m_left_q;

  logic in_region;
  logic click;
  logic goal;

  // Only the press edge counts, and only if the pointer is on the button then.
  assign in_region = (bus.xpos_mouse >= X0) && (bus.xpos_mouse <= X1) &&
                     (bus.ypos_mouse >= Y0) && (bus.ypos_mouse <= Y1);
  assign click     = bus.m_left && !m_left_q && in_region;
  assign goal      = (bus.ypos_player >= GY);

  always_ff @(posedge clk_40) begin
    if (rst) begin
      state_q       <= START;
      level_q       <= '0;
      lives_q       <= LIVES_INIT;
      level_start_q <= 1'b0;
      timer_q       <= '0;
      m_left_q      <= 1'b0;
    end else begin
      m_left_q      <= bus.m_left;
      level_start_q <= 1'b0;
      case (state_q)
        START: begin
          if (click) begin
            state_q       <= PLAY;
            level_q       <= '0;
            lives_q       <= LIVES_INIT;
            level_start_q <= 1'b1;
          end
        end
        PLAY: begin
          if (bus.player_hit) begin
            state_q <= DEAD;
            timer_q <= '0;
            if (lives_q != '0) lives_q <= lives_q - LVW'(1);
          end else if (goal) begin
            if (level_q == LAST_LEVEL) begin
              state_q <= FINISH;
            end else begin
              state_q <= LEVEL_UP;
              timer_q <= '0;
            end
          end
        end
        LEVEL_UP: begin
          if (timer_q == HOLD_LAST) begin
            state_q       <= PLAY;
            level_start_q <= 1'b1;
            if (level_q != LAST_LEVEL) level_q <= level_q + LW'(1);
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        DEAD: begin
          if (timer_q == HOLD_LAST) begin
            if (lives_q == '0) begin
              state_q <= GAME_OVER;
            end else begin
              state_q       <= PLAY;
              level_start_q <= 1'b1;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        GAME_OVER, FINISH: begin
          if (click) state_q <= START;
        end
        default: state_q <= START;
      endcase
    end
  end

  assign bus.game_state  = state_q;
  assign bus.level       = level_q;
  assign bus.lives       = lives_q;
  assign bus.level_start = level_start_q;
endmodule

// File: tb/tb_level_sequencer.sv
// Bench for level_sequencer: directed scenarios with literal expectations,
// then random stimulus checked every cycle against a countdown-based model.
module tb_level_sequencer;
  import level_sequencer_pkg::*;

  localparam int N_LEVELS = 3;
  localparam int LIVES    = 3;
  localparam int HOLD_CYC = 4;
  localparam int GOAL_Y   = 500;

  logic clk_40 = 1'b0;
  logic rst;
  always #5 clk_40 = ~clk_40;

  level_sequencer_if #(.N_LEVELS(N_LEVELS), .LIVES(LIVES)) bus ();

  level_sequencer #(
    .N_LEVELS(N_LEVELS), .LIVES(LIVES), .HOLD_CYC(HOLD_CYC),
    .BTN_X0(160), .BTN_X1(650), .BTN_Y0(250), .BTN_Y1(320), .GOAL_Y(GOAL_Y)
  ) dut (
    .clk_40(clk_40),
    .rst   (rst),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Reference model: hold states tracked as "cycles remaining".
  int  m_st    = int'(START);
  int  m_lvl   = 0;
  int  m_lives = LIVES;
  int  m_ls    = 0;
  int  m_left_prev = 0;
  int  m_remain = 0;

  function automatic bit on_button(input int x, input int y);
    return (x >= 160 && x <= 650 && y >= 250 && y <= 320);
  endfunction

  always @(posedge clk_40) begin : model
    int st, lvl, lv, ls, rem;
    bit clk_ev;
    st = m_st; lvl = m_lvl; lv = m_lives; rem = m_remain; ls = 0;
    clk_ev = (bus.m_left === 1'b1) && (m_left_prev == 0) &&
             on_button(int'(bus.xpos_mouse), int'(bus.ypos_mouse));
    if (rst === 1'b1) begin
      st = int'(START); lvl = 0; lv = LIVES; rem = 0;
    end else begin
      if (st == int'(START)) begin
        if (clk_ev) begin st = int'(PLAY); lvl = 0; lv = LIVES; ls = 1; end
      end else if (st == int'(PLAY)) begin
        if (bus.player_hit === 1'b1) begin
          st = int'(DEAD); lv = (lv > 0) ? lv - 1 : 0; rem = HOLD_CYC;
        end else if (int'(bus.ypos_player) >= GOAL_Y) begin
          if (lvl == N_LEVELS - 1) st = int'(FINISH);
          else begin st = int'(LEVEL_UP); rem = HOLD_CYC; end
        end
      end else if (st == int'(LEVEL_UP) || st == int'(DEAD)) begin
        rem = rem - 1;
        if (rem == 0) begin
          if (st == int'(LEVEL_UP)) begin lvl = lvl + 1; st = int'(PLAY); ls = 1; end
          else if (lv == 0) st = int'(GAME_OVER);
          else begin st = int'(PLAY); ls = 1; end
        end
      end else begin
        if (clk_ev) st = int'(START);
      end
    end
    m_st     <= st;
    m_lvl    <= lvl;
    m_lives  <= lv;
    m_ls     <= ls;
    m_remain <= rem;
    m_left_prev <= (rst === 1'b1) ? 0 : int'(bus.m_left === 1'b1);
  end

  always @(negedge clk_40) begin : compare
    if (chk_en) begin
      check("model_state", int'(bus.game_state), m_st);
      check("model_level", int'(bus.level), m_lvl);
      check("model_lives", int'(bus.lives), m_lives);
      check("model_level_start", int'(bus.level_start), m_ls);
    end
  end

  // Apply inputs at a falling edge; returns at the next falling edge.
  task automatic drive(input bit ml, input int x, input int y, input int yp,
                       input bit hit, input bit r);
    bus.m_left      = ml;
    bus.xpos_mouse  = 12'(x);
    bus.ypos_mouse  = 12'(y);
    bus.ypos_player = 12'(yp);
    bus.player_hit  = hit;
    rst             = r;
    @(negedge clk_40);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 400, 300, 0, 1'b0, 1'b0);
  endtask

  task automatic expect_out(input string nm, input g_state st, input int lvl,
                            input int lv, input int ls);
    check({nm, ".state"}, int'(bus.game_state), int'(st));
    check({nm, ".level"}, int'(bus.level), lvl);
    check({nm, ".lives"}, int'(bus.lives), lv);
    check({nm, ".level_start"}, int'(bus.level_start), ls);
  endtask

  task automatic hit_and_hold();
    drive(1'b0, 400, 300, 0, 1'b1, 1'b0);
    idle(HOLD_CYC);
  endtask

  initial begin
    bus.m_left = 1'b0; bus.xpos_mouse = '0; bus.ypos_mouse = '0;
    bus.ypos_player = '0; bus.player_hit = 1'b0; rst = 1'b1;
    @(negedge clk_40);
    drive(1'b0, 0, 0, 0, 1'b0, 1'b1);
    chk_en = 1'b1;
    expect_out("reset", START, 0, LIVES, 0);

    // Presses just outside the button are ignored.
    drive(1'b1, 159, 300, 0, 1'b0, 1'b0);
    expect_out("press_x159", START, 0, 3, 0);
    drive(1'b1, 400, 300, 0, 1'b0, 1'b0);
    expect_out("held_enter_region", START, 0, 3, 0);
    idle(1);
    drive(1'b1, 400, 321, 0, 1'b0, 1'b0);
    expect_out("press_y321", START, 0, 3, 0);
    idle(1);

    // Valid click, then keep holding: exactly one level_start pulse.
    drive(1'b1, 400, 300, 0, 1'b0, 1'b0);
    expect_out("click_start", PLAY, 0, 3, 1);
    drive(1'b1, 400, 300, 0, 1'b0, 1'b0);
    expect_out("held_in_play", PLAY, 0, 3, 0);
    idle(1);

    // Goal at level 0 -> LEVEL_UP for HOLD_CYC cycles -> level 1.
    drive(1'b0, 400, 300, 500, 1'b0, 1'b0);
    expect_out("goal_l0", LEVEL_UP, 0, 3, 0);
    idle(HOLD_CYC - 1);
    expect_out("levelup_hold", LEVEL_UP, 0, 3, 0);
    idle(1);
    expect_out("levelup_exit", PLAY, 1, 3, 1);

    // Hit beats goal in the same cycle.
    drive(1'b0, 400, 300, 600, 1'b1, 1'b0);
    expect_out("hit_vs_goal", DEAD, 1, 2, 0);
    idle(HOLD_CYC - 1);
    expect_out("dead_hold", DEAD, 1, 2, 0);
    idle(1);
    expect_out("dead_exit", PLAY, 1, 2, 1);

    drive(1'b0, 400, 300, 500, 1'b0, 1'b0);
    idle(HOLD_CYC);
    expect_out("to_level2", PLAY, 2, 2, 1);
    drive(1'b0, 400, 300, 4095, 1'b0, 1'b0);
    expect_out("finish", FINISH, 2, 2, 0);
    drive(1'b1, 160, 250, 0, 1'b0, 1'b0);
    expect_out("finish_click", START, 2, 2, 0);
    idle(1);

    // Three hits -> GAME_OVER, then restart.
    drive(1'b1, 650, 320, 0, 1'b0, 1'b0);
    expect_out("restart", PLAY, 0, 3, 1);
    idle(1);
    hit_and_hold();
    hit_and_hold();
    expect_out("two_hits", PLAY, 0, 1, 1);
    hit_and_hold();
    expect_out("game_over", GAME_OVER, 0, 0, 0);
    drive(1'b0, 400, 300, 0, 1'b1, 1'b0);
    expect_out("go_ignore_hit", GAME_OVER, 0, 0, 0);
    drive(1'b1, 400, 300, 0, 1'b0, 1'b0);
    expect_out("go_click", START, 0, 0, 0);
    idle(1);
    drive(1'b1, 400, 300, 0, 1'b0, 1'b0);
    expect_out("new_game", PLAY, 0, 3, 1);
    idle(1);

    // Reset in the middle of LEVEL_UP; a click with reset is discarded.
    drive(1'b0, 400, 300, 500, 1'b0, 1'b0);
    idle(1);
    drive(1'b1, 400, 300, 0, 1'b0, 1'b1);
    expect_out("rst_mid_levelup", START, 0, 3, 0);
    idle(1);
    expect_out("rst_click_dropped", START, 0, 3, 0);

    // Randomised phase.
    for (int i = 0; i < 3000; i++) begin
      bit ml, hit, r;
      int x, y, yp;
      ml  = ($urandom_range(0, 2) == 0) ? ~bus.m_left : bus.m_left;
      x   = ($urandom_range(0, 3) != 0) ? int'($urandom_range(160, 650))
                                        : int'($urandom_range(0, 4095));
      y   = ($urandom_range(0, 3) != 0) ? int'($urandom_range(249, 321))
                                        : int'($urandom_range(0, 4095));
      yp  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(495, 4095))
                                        : int'($urandom_range(0, 499));
      hit = ($urandom_range(0, 11) == 0);
      r   = ($urandom_range(0, 149) == 0);
      drive(ml, x, y, yp, hit, r);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/level_sequencer.md
LEVEL_SEQUENCER -- requirements
Module: level_sequencer

Interface
REQ-001 The block SHALL have one clock, clk_40; reset rst SHALL be synchronous and active-high.
REQ-002 Parameter N_LEVELS, 3, number of playable levels (>=1).
REQ-003 Parameter LIVES, 3, lives granted at game start (>=1).
REQ-004 Parameter HOLD_CYC, 40_000_000, duration in cycles of the LEVEL_UP and DEAD hold states (>=1).
REQ-005 Parameters BTN_X0/BTN_X1/BTN_Y0/BTN_Y1, 160/650/250/320, inclusive click-region bounds.
REQ-006 Parameter GOAL_Y, 500, player y-position at or beyond which a level is complete.
REQ-007 clk_40  input  1  system clock.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 m_left  input  1  left mouse button level.
REQ-010 xpos_mouse  input  12  mouse x, unsigned.
REQ-011 ypos_mouse  input  12  mouse y, unsigned.
REQ-012 ypos_player  input  12  player y, unsigned.
REQ-013 player_hit  input  1  player killed this cycle (level).
REQ-014 game_state  output  g_state  current state: START, PLAY, LEVEL_UP, DEAD, GAME_OVER, FINISH.
REQ-015 level  output  $clog2(N_LEVELS+1)  current level index, 0-based.
REQ-016 lives  output  $clog2(LIVES+1)  remaining lives.
REQ-017 level_start  output  1  one-cycle pulse on the first cycle of each PLAY entry.

Function
REQ-018 click SHALL be a rising edge of m_left (m_left=1, registered m_left_d=0) with xpos_mouse in [BTN_X0,BTN_X1] and ypos_mouse in [BTN_Y0,BTN_Y1], all bounds inclusive.
REQ-019 A held button SHALL produce exactly one click; a press outside the region SHALL be ignored, including if the mouse later enters the region while held.
REQ-020 START: on click, go to PLAY; level<=0, lives<=LIVES.
REQ-021 PLAY: player_hit SHALL take priority over goal; on player_hit go to DEAD, lives<=lives-1.
REQ-022 PLAY: on ypos_player>=GOAL_Y without player_hit, go to FINISH if level==N_LEVELS-1, else to LEVEL_UP.
REQ-023 LEVEL_UP: remain exactly HOLD_CYC cycles, then go to PLAY with level<=level+1.
REQ-024 DEAD: remain exactly HOLD_CYC cycles, then go to GAME_OVER if lives==0, else to PLAY at the same level.
REQ-025 GAME_OVER and FINISH: on click, go to START; level and lives SHALL hold until then.
REQ-026 Hold timer width SHALL be $clog2(HOLD_CYC+1); cleared on hold-state entry; exit on the cycle timer==HOLD_CYC-1; no wrap.
REQ-027 level_start SHALL be registered and high only in the first PLAY cycle after entry from START, LEVEL_UP or DEAD.
REQ-028 player_hit and the goal condition SHALL be ignored outside PLAY; click SHALL be ignored outside START, GAME_OVER and FINISH.
REQ-029 lives SHALL never underflow, and level SHALL never exceed N_LEVELS-1.
REQ-030 All outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-031 rst=1 SHALL force game_state=START, level=0, lives=LIVES, level_start=0, timer=0 and m_left_d=0 on the next clock edge, from any state, overriding all other inputs.
REQ-032 A click in the same cycle as rst SHALL be discarded.

Verification (HOLD_CYC=4, N_LEVELS=3, LIVES=3)
REQ-033 Click at (400,300) in START -> PLAY next cycle, level=0, lives=3, level_start=1 for 1 cycle; a press at (159,300) or (400,321) -> remains START.
REQ-034 ypos_player=500 in PLAY at level 0 -> LEVEL_UP for 4 cycles -> PLAY with level=1 and a level_start pulse; at level 2 -> FINISH.
REQ-035 player_hit with ypos_player=600 in the same cycle -> DEAD (not LEVEL_UP), lives 3->2, then PLAY at the same level after 4 cycles.
REQ-036 Three hits -> after the third DEAD hold, GAME_OVER with lives=0; click -> START; a new click -> lives=3, level=0.
REQ-037 m_left held from START through entry to PLAY -> no extra click; rst asserted mid-LEVEL_UP -> START, level=0, lives=3 next cycle.
